// File: rtl/smart_house_cmd_sender_pkg.sv
// Shared smart-house link definitions: command IDs, ASCII constants, keyword tables,
// keyword lengths and the per-command checksum helper.
package smart_house_cmd_sender_pkg;

  typedef enum logic [1:0] {
    CMD_OPENWINDOW  = 2'd0,
    CMD_CLOSEWINDOW = 2'd1,
    CMD_LIGHTON     = 2'd2,
    CMD_MUSICOFF    = 2'd3
  } cmd_id_e;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SEND  = 2'd1,
    S_CKSUM = 2'd2,
    S_GAP   = 2'd3
  } state_e;

  localparam logic [7:0] IDLE_CHAR = 8'h00;

  localparam logic [7:0] CH_C = 8'h63;
  localparam logic [7:0] CH_D = 8'h64;
  localparam logic [7:0] CH_E = 8'h65;
  localparam logic [7:0] CH_F = 8'h66;
  localparam logic [7:0] CH_G = 8'h67;
  localparam logic [7:0] CH_H = 8'h68;
  localparam logic [7:0] CH_I = 8'h69;
  localparam logic [7:0] CH_L = 8'h6C;
  localparam logic [7:0] CH_M = 8'h6D;
  localparam logic [7:0] CH_N = 8'h6E;
  localparam logic [7:0] CH_O = 8'h6F;
  localparam logic [7:0] CH_P = 8'h70;
  localparam logic [7:0] CH_S = 8'h73;
  localparam logic [7:0] CH_T = 8'h74;
  localparam logic [7:0] CH_U = 8'h75;
  localparam logic [7:0] CH_W = 8'h77;

  localparam int LEN_OPENWINDOW  = 10;
  localparam int LEN_CLOSEWINDOW = 11;
  localparam int LEN_LIGHTON     = 7;
  localparam int LEN_MUSICOFF    = 8;
  localparam int LEN_MAX         = 11;

  // Keyword slots; index 0 is the first char on the wire, unused tail is IDLE_CHAR.
  localparam int KW_SLOTS = 12;
  typedef logic [0:KW_SLOTS-1][7:0] kw_t;

  localparam kw_t KW_OPENWINDOW = {CH_O, CH_P, CH_E, CH_N, CH_W, CH_I, CH_N, CH_D,
                                   CH_O, CH_W, IDLE_CHAR, IDLE_CHAR};
  localparam kw_t KW_CLOSEWINDOW = {CH_C, CH_L, CH_O, CH_S, CH_E, CH_W, CH_I, CH_N,
                                    CH_D, CH_O, CH_W, IDLE_CHAR};
  localparam kw_t KW_LIGHTON = {CH_L, CH_I, CH_G, CH_H, CH_T, CH_O, CH_N, IDLE_CHAR,
                                IDLE_CHAR, IDLE_CHAR, IDLE_CHAR, IDLE_CHAR};
  localparam kw_t KW_MUSICOFF = {CH_M, CH_U, CH_S, CH_I, CH_C, CH_O, CH_F, CH_F,
                                 IDLE_CHAR, IDLE_CHAR, IDLE_CHAR, IDLE_CHAR};

  function automatic kw_t kw_table(cmd_id_e id);
    case (id)
      CMD_OPENWINDOW:  return KW_OPENWINDOW;
      CMD_CLOSEWINDOW: return KW_CLOSEWINDOW;
      CMD_LIGHTON:     return KW_LIGHTON;
      default:         return KW_MUSICOFF;
    endcase
  endfunction

  function automatic int kw_len(cmd_id_e id);
    case (id)
      CMD_OPENWINDOW:  return LEN_OPENWINDOW;
      CMD_CLOSEWINDOW: return LEN_CLOSEWINDOW;
      CMD_LIGHTON:     return LEN_LIGHTON;
      default:         return LEN_MUSICOFF;
    endcase
  endfunction

  // XOR of the keyword chars with bit7 cleared so the beat stays 7-bit ASCII.
  function automatic logic [7:0] kw_cksum(cmd_id_e id);
    kw_t        kw;
    logic [7:0] acc;
    kw  = kw_table(id);
    acc = 8'h00;
    for (int i = 0; i < KW_SLOTS; i++) begin
      if (i < kw_len(id)) acc = acc ^ kw[i];
    end
    return acc & 8'h7F;
  endfunction

endpackage

// File: rtl/smart_house_cmd_sender_if.sv
// Command/char link bundle: the control panel (master) issues commands and paces the
// char stream; the sender (slave) answers with keyword chars and status.
interface smart_house_cmd_sender_if;
  logic       cmd_valid;
  logic [1:0] cmd_id;
  logic       cmd_ready;
  logic [7:0] char_out;
  logic       char_valid;
  logic       char_ready;
  logic       busy;
  logic       done;

  modport master (
    output cmd_valid, cmd_id, char_ready,
    input  cmd_ready, char_out, char_valid, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_id, char_ready,
    output cmd_ready, char_out, char_valid, busy, done
  );
endinterface

// File: rtl/smart_house_cmd_sender_rom.sv
// Combinational keyword ROM: (cmd_id, idx) -> char and cmd_id -> keyword length.
// Address idx == len yields the precomputed checksum beat for that command.
module smart_house_cmd_sender_rom
  import smart_house_cmd_sender_pkg::*;
#(
  parameter int IDX_W = 4
) (
  input  logic [1:0]       i_cmd_id,
  input  logic [IDX_W-1:0] i_idx,
  output logic [7:0]       o_char,
  output logic [IDX_W-1:0] o_len
);

  logic [IDX_W-1:0] w_len_tbl   [4];
  logic [7:0]       w_cksum_tbl [4];
  kw_t              w_kw_tbl    [4];

  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_cmd
      localparam cmd_id_e ID = cmd_id_e'(2'(gi));
      assign w_len_tbl[gi]   = IDX_W'(kw_len(ID));
      assign w_cksum_tbl[gi] = kw_cksum(ID);
      assign w_kw_tbl[gi]    = kw_table(ID);
    end
  endgenerate

  assign o_len = w_len_tbl[i_cmd_id];

  always_comb begin
    o_char = IDLE_CHAR;
    for (int k = 0; k < KW_SLOTS; k++) begin
      if ((k == int'(i_idx)) && (k < int'(o_len))) o_char = w_kw_tbl[i_cmd_id][k];
    end
    if (i_idx == o_len) o_char = w_cksum_tbl[i_cmd_id];
  end

endmodule

// File: rtl/smart_house_cmd_sender.sv
// Smart-house command sender: serialises a command keyword onto the char stream, then
// idles the line for GAP_CYCLES. Define SENDER_CHECKSUM_EN to append a checksum beat.
module smart_house_cmd_sender
  import smart_house_cmd_sender_pkg::*;
#(
  parameter int GAP_CYCLES = 2,
  parameter int MAX_LEN    = 12
) (
  input logic                       clock,
  input logic                       reset,
  smart_house_cmd_sender_if.slave   bus
);

  localparam int IDX_W = $clog2(MAX_LEN + 1);
  localparam int GAP_W = (GAP_CYCLES > 2) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  generate
    if (LEN_MAX > MAX_LEN) begin : g_len_check
      $error("smart_house_cmd_sender: keyword longer than MAX_LEN");
    end
  endgenerate

  state_e           r_state;
  logic [1:0]       r_cmd;
  logic [IDX_W-1:0] r_idx;
  logic [GAP_W-1:0] r_gap_cnt;
  logic             r_cmd_ready;
  logic [7:0]       r_char_out;
  logic             r_char_valid;
  logic             r_busy;
  logic             r_done;

  logic [1:0]       w_rom_cmd;
  logic [IDX_W-1:0] w_rom_idx;
  logic [7:0]       w_rom_char;
  logic [IDX_W-1:0] w_len;
  logic             w_beat;
  logic             w_kw_end;
  logic             w_last_beat;

  // The ROM always looks one char ahead, so the registered char_out never bubbles.
  assign w_rom_cmd = (r_state == S_IDLE) ? bus.cmd_id : r_cmd;
  assign w_rom_idx = (r_state == S_IDLE) ? '0 : r_idx + 1'b1;

  smart_house_cmd_sender_rom #(
    .IDX_W (IDX_W)
  ) u_rom (
    .i_cmd_id (w_rom_cmd),
    .i_idx    (w_rom_idx),
    .o_char   (w_rom_char),
    .o_len    (w_len)
  );

  assign w_beat   = r_char_valid & bus.char_ready;
  assign w_kw_end = (r_idx == w_len - 1'b1);

`ifdef SENDER_CHECKSUM_EN
  assign w_last_beat = w_beat && (r_state == S_CKSUM);
`else
  assign w_last_beat = w_beat && (r_state == S_SEND) && w_kw_end;
`endif

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_cmd        <= 2'd0;
      r_idx        <= '0;
      r_gap_cnt    <= '0;
      r_cmd_ready  <= 1'b1;
      r_char_out   <= IDLE_CHAR;
      r_char_valid <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (bus.cmd_valid) begin
            r_cmd        <= bus.cmd_id;
            r_idx        <= '0;
            r_busy       <= 1'b1;
            r_cmd_ready  <= 1'b0;
            r_char_valid <= 1'b1;
            r_char_out   <= w_rom_char;
            r_state      <= S_SEND;
          end
        end
        S_SEND, S_CKSUM: begin
          if (w_last_beat) begin
            r_char_valid <= 1'b0;
            r_char_out   <= IDLE_CHAR;
            r_done       <= 1'b1;
            if (GAP_CYCLES == 0) begin
              r_state     <= S_IDLE;
              r_cmd_ready <= 1'b1;
              r_busy      <= 1'b0;
            end else begin
              r_state   <= S_GAP;
              r_gap_cnt <= GAP_LOAD;
            end
          end else if (w_beat) begin
            // With the checksum enabled idx steps to len, where the ROM holds the checksum.
            r_idx      <= w_rom_idx;
            r_char_out <= w_rom_char;
`ifdef SENDER_CHECKSUM_EN
            if (w_kw_end) r_state <= S_CKSUM;
`endif
          end
        end
        S_GAP: begin
          if (r_gap_cnt == '0) begin
            r_state     <= S_IDLE;
            r_cmd_ready <= 1'b1;
            r_busy      <= 1'b0;
          end else begin
            r_gap_cnt <= r_gap_cnt - 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.cmd_ready  = r_cmd_ready;
  assign bus.char_out   = r_char_out;
  assign bus.char_valid = r_char_valid;
  assign bus.busy       = r_busy;
  assign bus.done       = r_done;

endmodule

// File: tb/tb_smart_house_cmd_sender.sv
// Bench for smart_house_cmd_sender: two instances (GAP_CYCLES=2 and 0) share stimulus and
// are checked every cycle against a keyword-stream model, plus directed literal checks.
module tb_smart_house_cmd_sender;

`ifdef SENDER_CHECKSUM_EN
  localparam int CK = 1;
`else
  localparam int CK = 0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic [1:0] cmd_id = 2'd0;
  logic       char_ready = 1'b0;

  smart_house_cmd_sender_if if0 ();
  smart_house_cmd_sender_if if1 ();

  assign if0.cmd_valid  = cmd_valid;
  assign if0.cmd_id     = cmd_id;
  assign if0.char_ready = char_ready;
  assign if1.cmd_valid  = cmd_valid;
  assign if1.cmd_id     = cmd_id;
  assign if1.char_ready = char_ready;

  smart_house_cmd_sender #(.GAP_CYCLES(2), .MAX_LEN(12)) dut0 (
    .clock (clock), .reset (reset), .bus (if0)
  );
  smart_house_cmd_sender #(.GAP_CYCLES(0), .MAX_LEN(12)) dut1 (
    .clock (clock), .reset (reset), .bus (if1)
  );

  initial forever #5 clock = ~clock;

  // {cmd_ready, char_valid, char_out[7:0], busy, done}
  logic [11:0] o_pack [2];
  assign o_pack[0] = {if0.cmd_ready, if0.char_valid, if0.char_out, if0.busy, if0.done};
  assign o_pack[1] = {if1.cmd_ready, if1.char_valid, if1.char_out, if1.busy, if1.done};

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
  endtask

  task automatic chk_s(input string name, input string act, input string exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got \"%s\" expected \"%s\"", name, act, exp);
  endtask

  // ---------------- reference model: streams of keyword bytes ----------------
  string kw [4] = '{"openwindow", "closewindow", "lighton", "musicoff"};

  function automatic int gap_of(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic logic [7:0] cksum_of(input int id);
    logic [7:0] c = 8'h00;
    for (int i = 0; i < kw[id].len(); i++) c = c ^ kw[id][i];
    return c & 8'h7F;
  endfunction

  function automatic int beats_of(input int id);
    return kw[id].len() + CK;
  endfunction

  function automatic logic [7:0] stream_char(input int id, input int pos);
    if (pos < kw[id].len()) return kw[id][pos];
    return cksum_of(id);
  endfunction

  bit m_valid = 1'b0;
  bit m_idle [2];
  bit m_send [2];
  bit m_done [2];
  int m_id   [2];
  int m_pos  [2];
  int m_gap  [2];

  function automatic logic [11:0] model_pack(input int d);
    logic [7:0] ch;
    ch = m_send[d] ? stream_char(m_id[d], m_pos[d]) : 8'h00;
    return {m_idle[d], m_send[d], ch, ~m_idle[d], m_done[d]};
  endfunction

  task automatic model_step(input int d);
    bit nd = 1'b0;
    if (reset) begin
      m_idle[d] = 1'b1; m_send[d] = 1'b0; m_done[d] = 1'b0; m_gap[d] = 0; m_pos[d] = 0;
      return;
    end
    if (m_idle[d]) begin
      if (cmd_valid) begin
        m_idle[d] = 1'b0; m_send[d] = 1'b1; m_id[d] = int'(cmd_id); m_pos[d] = 0;
      end
    end else if (m_send[d]) begin
      if (char_ready) begin
        m_pos[d]++;
        if (m_pos[d] == beats_of(m_id[d])) begin
          m_send[d] = 1'b0;
          nd = 1'b1;
          if (gap_of(d) == 0) m_idle[d] = 1'b1;
          else m_gap[d] = gap_of(d);
        end
      end
    end else begin
      m_gap[d]--;
      if (m_gap[d] == 0) m_idle[d] = 1'b1;
    end
    m_done[d] = nd;
  endtask

  // ---------------- per-cycle monitor ----------------
  string rec       [2];
  int    done_cnt  [2];
  int    done_cyc  [2];
  int    acc_cnt   [2];
  int    acc_first [2];
  int    acc_last  [2];
  int    last_beat [2];
  int    rise_cyc  [2];
  int    first_lat [2];
  bit    first_pend[2];
  bit    prev_ready[2];

  task automatic clear_mon();
    for (int d = 0; d < 2; d++) begin
      rec[d] = ""; done_cnt[d] = 0; done_cyc[d] = -1; acc_cnt[d] = 0; acc_first[d] = -1;
      acc_last[d] = -1; last_beat[d] = -1; rise_cyc[d] = -1; first_lat[d] = -1;
      first_pend[d] = 1'b0;
    end
  endtask

  initial begin
    clear_mon();
    forever begin
      @(negedge clock);
      cyc++;
      for (int d = 0; d < 2; d++) begin
        if (m_valid) begin
          n_checks++;
          if (o_pack[d] === model_pack(d)) n_pass++;
          else $display("FAIL cycle_dut%0d at cycle %0d: got %03h expected %03h",
                        d, cyc, o_pack[d], model_pack(d));
          if (o_pack[d][10] && char_ready) begin
            rec[d] = $sformatf("%s%c", rec[d], o_pack[d][9:2]);
            last_beat[d] = cyc;
            if (first_pend[d]) begin
              first_lat[d]  = cyc - acc_last[d];
              first_pend[d] = 1'b0;
            end
          end
          if (cmd_valid && o_pack[d][11] && !reset) begin
            acc_cnt[d]++;
            if (acc_cnt[d] == 1) acc_first[d] = cyc;
            acc_last[d]   = cyc;
            first_pend[d] = 1'b1;
          end
          if (o_pack[d][0]) begin
            done_cnt[d]++;
            done_cyc[d] = cyc;
          end
          if (o_pack[d][11] && !prev_ready[d]) rise_cyc[d] = cyc;
          prev_ready[d] = o_pack[d][11];
        end
        model_step(d);
      end
      if (reset) m_valid = 1'b1;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic wait_idle();
    int k = 0;
    while (!(if0.cmd_ready && if1.cmd_ready) && k < 200) begin
      @(negedge clock);
      k++;
    end
    chk("wait_idle_in_time", int'(k < 200), 1);
    step();
    step();
  endtask

  string exp_s;

  initial begin
    chk("model_cksum_openwindow", int'(cksum_of(0)), 8'h18);

    reset = 1'b1;
    repeat (3) step();
    reset = 1'b0;
    @(negedge clock);
    chk("reset_cmd_ready", int'(if0.cmd_ready), 1);
    chk("reset_char_valid", int'(if0.char_valid), 0);
    chk("reset_char_out", int'(if0.char_out), 0);
    chk("reset_busy_done", int'({if0.busy, if0.done}), 0);
    step();

    // 1: openwindow with the receiver always ready
    clear_mon();
    char_ready = 1'b1; cmd_id = 2'd0; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_idle();
    exp_s = (CK != 0) ? $sformatf("openwindow%c", 8'h18) : "openwindow";
    chk_s("t1_stream_dut0", rec[0], exp_s);
    chk_s("t1_stream_dut1", rec[1], exp_s);
    chk("t1_first_latency", first_lat[0], 1);
    chk("t1_done_count_dut0", done_cnt[0], 1);
    chk("t1_done_count_dut1", done_cnt[1], 1);
    chk("t1_done_after_last_dut0", done_cyc[0] - last_beat[0], 1);
    chk("t1_ready_return_dut0", rise_cyc[0] - last_beat[0], 3);
    chk("t1_ready_return_dut1", rise_cyc[1] - last_beat[1], 1);
    chk("t6_done_with_ready_dut1", done_cyc[1], rise_cyc[1]);

    // 2: lighton with a three-cycle stall on the 'g' beat
    clear_mon();
    cmd_id = 2'd2; cmd_valid = 1'b1; char_ready = 1'b1;
    step();
    cmd_valid = 1'b0;
    step();
    step();
    char_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      chk($sformatf("t2_hold_char_%0d", i), int'(if0.char_out), 8'h67);
      chk($sformatf("t2_hold_valid_%0d", i), int'(if0.char_valid), 1);
      step();
    end
    char_ready = 1'b1;
    wait_idle();
    exp_s = (CK != 0) ? $sformatf("lighton%c", cksum_of(2)) : "lighton";
    chk_s("t2_stream_dut0", rec[0], exp_s);
    chk("t2_beat_count", rec[0].len(), 7 + CK);

    // 3: reset while the 5th char of closewindow is on the line
    clear_mon();
    cmd_id = 2'd1; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    repeat (4) step();
    chk("t3_fifth_char", int'(if0.char_out), 8'h65);
    reset = 1'b1;
    step();
    @(negedge clock);
    chk("t3_reset_outputs_dut0", int'(o_pack[0]), 12'h800);
    chk("t3_reset_outputs_dut1", int'(o_pack[1]), 12'h800);
    step();
    reset = 1'b0;
    step();
    clear_mon();
    cmd_id = 2'd3; cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
    wait_idle();
    exp_s = (CK != 0) ? $sformatf("musicoff%c", cksum_of(3)) : "musicoff";
    chk_s("t3_stream_after_reset", rec[0], exp_s);

    // 4: cmd_valid held high across a whole command and its gap
    clear_mon();
    cmd_id = 2'd2; cmd_valid = 1'b1;
    repeat (11 + CK) step();
    cmd_valid = 1'b0;
    wait_idle();
    chk("t4_accepts_dut0", acc_cnt[0], 2);
    chk("t4_accept_spacing_dut0", acc_last[0] - acc_first[0], 10 + CK);
    chk("t4_accepts_dut1", acc_cnt[1], 2);
    chk("t4_accept_spacing_dut1", acc_last[1] - acc_first[1], 8 + CK);

    // random traffic with occasional resets
    for (int i = 0; i < 2500; i++) begin
      cmd_valid  = ($urandom_range(0, 2) == 0);
      cmd_id     = 2'($urandom_range(0, 3));
      char_ready = ($urandom_range(0, 3) != 0);
      reset      = ($urandom_range(0, 149) == 0);
      step();
    end
    reset = 1'b0; cmd_valid = 1'b0; char_ready = 1'b1;
    wait_idle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
